seq_signed_div: RTL and testbench
=================================

SEQ_SIGNED_DIV -- requirements
Module: seq_signed_div

Interface
REQ-001 SHALL have parameter D_IN, default 8, giving the operand width in bits (legal range 4..32).
REQ-002 SHALL have input clk, 1 bit: clock; all state changes occur on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input start, 1 bit: request to begin a division.
REQ-005 SHALL have input N, D_IN bits: signed two's-complement dividend.
REQ-006 SHALL have input D, D_IN bits: signed two's-complement divisor.
REQ-007 SHALL have output busy, 1 bit: a division is in progress.
REQ-008 SHALL have output done, 1 bit: one-cycle pulse marking Q/R valid.
REQ-009 SHALL have output Q, D_IN bits: signed quotient.
REQ-010 SHALL have output R, D_IN bits: signed remainder.
REQ-011 SHALL have output dbz, 1 bit: divide-by-zero flag for the current result.
REQ-012 SHALL have output ovf, 1 bit: signed-overflow flag for the current result.

Function
REQ-013 SHALL compute Q = trunc(N/D) (rounded toward zero) and R = N - Q*D, so R is zero or has the sign of N with |R| < |D|.
REQ-014 SHALL use an FSM with states IDLE, CALC, FIX and DONE.
REQ-015 SHALL, in IDLE, accept start=1 at edge k: capture N, D, their signs and magnitudes (D_IN+1-bit magnitude so -2^(D_IN-1) is exact), set busy=1, and enter CALC.
REQ-016 SHALL, in CALC, perform one restoring step per cycle (shift remainder:dividend left one bit, trial-subtract |D|, set the quotient bit on non-negative result) for exactly D_IN cycles, counted by a down-counter.
REQ-017 SHALL, in FIX, apply signs: negate Q if sign(N)!=sign(D); negate R if N<0.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, drop busy, and return to IDLE; total latency is edge k to the done-high cycle = D_IN+2 cycles.
REQ-019 SHALL hold Q, R, dbz and ovf stable from done until the next accepted start.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL ignore changes on N/D after capture.
REQ-022 SHALL, when D=0 at capture, skip CALC/FIX, go directly to DONE (latency 1), and output Q=all ones, R=N, dbz=1, ovf=0.
REQ-023 SHALL accept back-to-back operation: start=1 in the IDLE cycle immediately following done is accepted.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, Q=0, R=0, dbz=0, ovf=0, and clear the counter.
REQ-025 SHALL, on reset asserted mid-division, abandon the operation with no done pulse; the first start after release begins a fresh division.

Configuration
REQ-026 SHALL support macro SEQ_DIV_OVF_SAT_EN for the case N=-2^(D_IN-1), D=-1.
REQ-027 SHALL, when SEQ_DIV_OVF_SAT_EN is defined, output Q=2^(D_IN-1)-1 (saturated), R=0, ovf=1 for that case.
REQ-028 SHALL, when SEQ_DIV_OVF_SAT_EN is undefined, output Q=-2^(D_IN-1) (wrapped), R=0, with ovf tied to 0; the port list is identical in both builds.

Structure
REQ-029 SHALL place the FSM state enum typedef and the default-width constant in shared package seq_div_pkg.
REQ-030 SHALL implement the single restoring step (shift, trial subtract, quotient bit) in combinational sub-module seq_div_step, instantiated once.

Verification
REQ-031 SHALL verify, with D_IN=8: N=127, D=-127 -> Q=-1, R=0, done exactly 10 cycles after start.
REQ-032 SHALL verify: N=-128, D=127 -> Q=-1, R=-1; N=-128, D=-128 -> Q=1, R=0; N=-5, D=-11 -> Q=0, R=-5; N=-100, D=7 -> Q=-14, R=-2.
REQ-033 SHALL verify: N=5, D=0 -> done 1 cycle after start with Q=8'hFF, R=5, dbz=1.
REQ-034 SHALL verify: N=-128, D=-1 -> Q=127, ovf=1 with SEQ_DIV_OVF_SAT_EN defined; Q=-128, ovf=0 without it.
REQ-035 SHALL verify: start re-pulsed with new operands mid-CALC -> ignored, first result unchanged; rst_n low at cycle 4 -> no done, all outputs 0.
REQ-036 SHALL verify: start held high continuously -> back-to-back results, each done separated by D_IN+3 cycles.

Source files
------------

// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
//   Shared declarations for the sequential signed divider:
//     - div_state_t           : FSM state encoding (IDLE, CALC, FIX, DONE)
//     - SEQ_DIV_D_IN_DEFAULT  : default operand width
//     - seq_div_cnt_w()       : width of the step down-counter for a given width
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int SEQ_DIV_D_IN_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // The counter must hold the full step count D_IN, not D_IN-1.
    function automatic int seq_div_cnt_w(input int d_in);
        return $clog2(d_in + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// -----------------------------------------------------------------------------
// seq_div_step
//   One combinational restoring-division step on unsigned magnitudes.
//   The {remainder, dividend} pair is shifted left by one bit, the divisor
//   magnitude is trial-subtracted from the widened remainder, and the new
//   quotient bit is 1 when the trial result is non-negative.
//
// Ports
//   rem_i  [W:0]   : partial remainder before the step
//   quo_i  [W-1:0] : dividend bits still to shift in / quotient bits so far
//   dmag_i [W:0]   : divisor magnitude (W+1 bits so 2^(W-1) is exact)
//   rem_o  [W:0]   : partial remainder after the step
//   quo_o  [W-1:0] : shifted dividend with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int W = SEQ_DIV_D_IN_DEFAULT
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W:0]   dmag_i,
    output logic [W:0]   rem_o,
    output logic [W-1:0] quo_o
);

    localparam int RW = W + 1;

    logic [W+1:0] rem_sh;
    logic         ge;

    always_comb begin
        rem_sh = {rem_i, quo_i[W-1]};
        ge     = (rem_sh >= {1'b0, dmag_i});
        // The remainder always stays below |D| <= 2^(W-1), so the top bit of
        // the widened shift result is only needed for the comparison.
        rem_o  = ge ? RW'(rem_sh - {1'b0, dmag_i}) : RW'(rem_sh);
        quo_o  = {quo_i[W-2:0], ge};
    end

endmodule

// File: rtl/seq_signed_div.sv
// -----------------------------------------------------------------------------
// seq_signed_div
//   Sequential signed divider, one restoring step per clock.
//   Q = trunc(N/D) (toward zero), R = N - Q*D (sign of N, |R| < |D|).
//   Latency from the start-accepting edge: D_IN+1 edges to enter DONE
//   (done high in the D_IN+2'th cycle counted from the start cycle);
//   a zero divisor goes straight to DONE.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a division (taken only in IDLE)
//   N, D   : signed dividend / divisor, captured when start is taken
//   busy   : high while CALC or FIX is in progress
//   done   : one-cycle pulse, Q/R/dbz/ovf valid from here on
//   Q, R   : signed quotient / remainder, held until the next result
//   dbz    : divide-by-zero flag for the current result
//   ovf    : signed-overflow flag (only meaningful with SEQ_DIV_OVF_SAT_EN)
//
// Build option
//   SEQ_DIV_OVF_SAT_EN : when defined, -2^(D_IN-1) / -1 saturates Q to the
//                        largest positive value and raises ovf; otherwise Q
//                        wraps to -2^(D_IN-1) and ovf is tied low.
// -----------------------------------------------------------------------------
module seq_signed_div
    import seq_div_pkg::*;
#(
    parameter int D_IN = SEQ_DIV_D_IN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [D_IN-1:0] N,
    input  logic [D_IN-1:0] D,
    output logic            busy,
    output logic            done,
    output logic [D_IN-1:0] Q,
    output logic [D_IN-1:0] R,
    output logic            dbz,
    output logic            ovf
);

    localparam int CNT_W = seq_div_cnt_w(D_IN);

    // Control and result registers (reset)
    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [D_IN-1:0]   q_q, q_d;
    logic [D_IN-1:0]   r_q, r_d;
    logic              dbz_q, dbz_d;

    // Working datapath registers (loaded on capture, no reset needed)
    logic [D_IN:0]     rem_q, rem_d;
    logic [D_IN-1:0]   quo_q, quo_d;
    logic [D_IN:0]     dmag_q, dmag_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;

    // Step sub-module results
    logic [D_IN:0]     step_rem;
    logic [D_IN-1:0]   step_quo;

    logic signed [D_IN-1:0] n_s;
    logic signed [D_IN-1:0] d_s;

`ifdef SEQ_DIV_OVF_SAT_EN
    logic              ovf_q, ovf_d;
    logic              ovf_case_q, ovf_case_d;
    localparam logic signed [D_IN-1:0] S_MIN = {1'b1, {(D_IN-1){1'b0}}};
    localparam logic signed [D_IN-1:0] S_MAX = {1'b0, {(D_IN-1){1'b1}}};
`endif

    // Two's-complement magnitude; the most negative value maps to 2^(D_IN-1),
    // which still fits as an unsigned D_IN-bit number.
    function automatic logic [D_IN-1:0] mag(input logic [D_IN-1:0] v);
        return v[D_IN-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [D_IN-1:0] neg(input logic [D_IN-1:0] v);
        return ~v + 1'b1;
    endfunction

    assign n_s = N;
    assign d_s = D;

    seq_div_step #(
        .W (D_IN)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dmag_i (dmag_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dmag_d  = dmag_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`ifdef SEQ_DIV_OVF_SAT_EN
        ovf_d      = ovf_q;
        ovf_case_d = ovf_case_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (D == '0) begin
                        // Zero divisor: result is fixed, no iteration needed.
                        q_d     = '1;
                        r_d     = N;
                        dbz_d   = 1'b1;
`ifdef SEQ_DIV_OVF_SAT_EN
                        ovf_d   = 1'b0;
`endif
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag(N);
                        dmag_d  = {1'b0, mag(D)};
                        q_neg_d = n_s[D_IN-1] ^ d_s[D_IN-1];
                        r_neg_d = n_s[D_IN-1];
                        cnt_d   = CNT_W'(D_IN);
`ifdef SEQ_DIV_OVF_SAT_EN
                        ovf_case_d = (n_s == S_MIN) && (d_s == -1);
`endif
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Magnitudes are final; restore signs. In the wrap case
                // (MIN / -1) the magnitude 2^(D_IN-1) is left un-negated and
                // reads back as MIN, which is the intended wrapped result.
                q_d   = q_neg_q ? neg(quo_q) : quo_q;
                r_d   = r_neg_q ? neg(rem_q[D_IN-1:0]) : rem_q[D_IN-1:0];
                dbz_d = 1'b0;
`ifdef SEQ_DIV_OVF_SAT_EN
                ovf_d = ovf_case_q;
                if (ovf_case_q) begin
                    q_d = S_MAX;
                    r_d = '0;
                end
`endif
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_OVF_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_OVF_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dmag_q  <= dmag_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
`ifdef SEQ_DIV_OVF_SAT_EN
        ovf_case_q <= ovf_case_d;
`endif
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
`ifdef SEQ_DIV_OVF_SAT_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_div.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_div
//   Self-checking bench for seq_signed_div with D_IN = 8. A behavioural model
//   (integer division plus an accept/latency rule) predicts every output on
//   every cycle; directed cases pin literal results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_signed_div;

    localparam int W = 8;
    localparam int LAT = W + 2;  // cycles from start cycle to done cycle

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] N;
    logic [W-1:0] D;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dbz;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    seq_signed_div #(.D_IN(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .N     (N),
        .D     (D),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the division rules.
    function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic o);
        int ni;
        int di;
        ni = $signed(n);
        di = $signed(d);
        z = 1'b0;
        o = 1'b0;
        if (di == 0) begin
            q = '1;
            r = n;
            z = 1'b1;
        end else if (ni == -128 && di == -1) begin
`ifdef SEQ_DIV_OVF_SAT_EN
            q = 8'h7F;
            o = 1'b1;
`else
            q = 8'h80;
`endif
            r = '0;
        end else begin
            q = W'(ni / di);
            r = W'(ni % di);
        end
    endfunction

    // Model state: which edge accepted the current op and when done is due.
    int           cyc = 0;
    bit           op_valid = 1'b0;
    int           m_acc_edge = 0;
    int           m_done_edge = 0;
    bit           m_zero = 1'b0;
    logic [W-1:0] m_q, m_r;
    logic         m_dbz, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid = 1'b0;
        end else begin
            cyc++;
            // A new op is taken only once the previous DONE cycle has passed.
            if (start && (!op_valid || cyc >= m_done_edge + 2)) begin
                op_valid    = 1'b1;
                m_acc_edge  = cyc;
                m_zero      = (D == '0);
                m_done_edge = cyc + (m_zero ? 0 : W + 1);
                model(N, D, m_q, m_r, m_dbz, m_ovf);
            end
        end
    end

    // Compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        if (!rst_n || !op_valid) begin
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_q", Q, 0);
            chk("idle_r", R, 0);
            chk("idle_dbz", dbz, 0);
            chk("idle_ovf", ovf, 0);
        end else begin
            chk("done", done, (cyc == m_done_edge));
            chk("busy", busy, (!m_zero && cyc >= m_acc_edge && cyc < m_done_edge));
            if (cyc >= m_done_edge) begin
                chk("q", Q, m_q);
                chk("r", R, m_r);
                chk("dbz", dbz, m_dbz);
                chk("ovf", ovf, m_ovf);
            end
        end
    end

    // Pulse start for one cycle, scramble operands afterwards, wait for done.
    task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, output int lat);
        @(negedge clk);
        start = 1'b1;
        N = n;
        D = d;
        @(negedge clk);
        start = 1'b0;
        N = W'($urandom);
        D = W'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("op_timeout", 0, 1);
    endtask

    logic [W-1:0] tn [6] = '{8'h7F, 8'h80, 8'h80, 8'hFB, 8'h9C, 8'h05};
    logic [W-1:0] td [6] = '{8'h81, 8'h7F, 8'h80, 8'hF5, 8'h07, 8'h00};
    logic [W-1:0] tq [6] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'hF2, 8'hFF};
    logic [W-1:0] tr [6] = '{8'h00, 8'hFF, 8'h00, 8'hFB, 8'hFE, 8'h05};
    int           tl [6] = '{10, 10, 10, 10, 10, 1};

    initial begin
        int lat;
        int gap;
        bit seen;
        logic [W-1:0] pq, pr;
        logic pz, po;
        logic [W-1:0] rn, rd;

        start = 1'b0;
        N = '0;
        D = '0;
        rst_n = 1'b0;

        // Pin the model itself against hand-computed values.
        for (int i = 0; i < 6; i++) begin
            model(tn[i], td[i], pq, pr, pz, po);
            chk($sformatf("model%0d_q", i), pq, tq[i]);
            chk($sformatf("model%0d_r", i), pr, tr[i]);
        end

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_q", Q, 0);
        chk("rst_done", done, 0);

        // Directed literal cases, including divide-by-zero latency.
        for (int i = 0; i < 6; i++) begin
            do_op(tn[i], td[i], lat);
            chk($sformatf("dir%0d_q", i), Q, tq[i]);
            chk($sformatf("dir%0d_r", i), R, tr[i]);
            chk($sformatf("dir%0d_lat", i), lat, tl[i]);
            chk($sformatf("dir%0d_dbz", i), dbz, (td[i] == 0));
        end

        // Most-negative / -1.
        do_op(8'h80, 8'hFF, lat);
        chk("ovf_r", R, 0);
`ifdef SEQ_DIV_OVF_SAT_EN
        chk("ovf_q", Q, 8'h7F);
        chk("ovf_flag", ovf, 1);
`else
        chk("ovf_q", Q, 8'h80);
        chk("ovf_flag", ovf, 0);
`endif

        // Start re-pulsed mid-CALC with new operands must be ignored.
        @(negedge clk);
        start = 1'b1; N = 8'h9C; D = 8'h07;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; N = 8'h32; D = 8'h03;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("repulse_done_seen", done, 1);
        chk("repulse_q", Q, 8'hF2);
        chk("repulse_r", R, 8'hFE);
        repeat (3) @(negedge clk);

        // Reset in the middle of a division.
        @(negedge clk);
        start = 1'b1; N = 8'h4D; D = 8'h05;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_q", Q, 0);
        chk("midrst_r", R, 0);
        chk("midrst_dbz", dbz, 0);
        chk("midrst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        do_op(8'h64, 8'h09, lat);
        chk("post_rst_q", Q, 8'h0B);
        chk("post_rst_r", R, 8'h01);
        chk("post_rst_lat", lat, LAT);

        // Start held high: back-to-back results.
        @(negedge clk);
        start = 1'b1; N = 8'h64; D = 8'h03;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_lat", lat, LAT);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done && gap < 40);
            chk($sformatf("b2b_gap%0d", k), gap, W + 3);
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        // Randomized operands, including zero divisors and extremes.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: rd = '0;
                1: rd = 8'hFF;
                2: rd = 8'h80;
                default: rd = W'($urandom);
            endcase
            rn = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
            do_op(rn, rd, lat);
            chk("rand_lat", lat, (rd == 0) ? 1 : LAT);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
